// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions and the TX state encoding.
package uart_tx_pkg;

  // Byte offsets of the four word registers inside the 16-byte window.
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_BAUD   = 4'hC;

  // fn3[1:0] encoding of a full-word access (fn3[2] is the sign bit, ignored).
  localparam logic [1:0] FN3_WORD = 2'b10;

  // STATUS bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  // CTRL bit positions.
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PAR_EN  = 2;
  localparam int CTRL_PAR_ODD = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART: store strobe, address, store data,
// access width, and the combinational read data / window-hit back to the core.
interface mmio_uart_tx_if;
  logic        wr_en;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [2:0]  fn3;
  logic [31:0] data_out;
  logic        hit;

  // Core side drives the request and consumes the response.
  modport master (output wr_en, addr_in, data_in, fn3, input data_out, hit);
  // Peripheral side decodes the request and returns read data.
  modport slave  (input wr_en, addr_in, data_in, fn3, output data_out, hit);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data. A push while full
// and a pop while empty are ignored; push and pop together move both pointers.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy update; pointers wrap because DEPTH is a power of 2.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty/count guard every read.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) on the core data-memory bus.
// Registers: TXDATA (push), STATUS, CTRL, BAUD_DIV. Optional build macro
// UART_TX_PARITY_EN adds CTRL par_en/par_odd and a PARITY bit slot.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] CTRL_WR_MASK = 4'b1111;
`else
  localparam logic [3:0] CTRL_WR_MASK = 4'b0011;
`endif

  // ---------------- bus decode ----------------
  logic aligned, reg_we, word_wr;
  logic push, wr_status, wr_ctrl, wr_baud;
  logic unused_bits;

  assign bus.hit   = (bus.addr_in[31:4] == BASE_ADDR[31:4]);
  assign aligned   = (bus.addr_in[1:0] == 2'b00);
  assign reg_we    = bus.wr_en & bus.hit & aligned;
  assign word_wr   = (bus.fn3[1:0] == FN3_WORD);
  assign push      = reg_we & (bus.addr_in[3:0] == OFF_TXDATA);
  assign wr_status = reg_we & word_wr & (bus.addr_in[3:0] == OFF_STATUS);
  assign wr_ctrl   = reg_we & word_wr & (bus.addr_in[3:0] == OFF_CTRL);
  assign wr_baud   = reg_we & word_wr & (bus.addr_in[3:0] == OFF_BAUD);
  assign unused_bits = ^{bus.data_in[31:16], bus.fn3[2]};

  // ---------------- FIFO ----------------
  logic             pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.data_in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- registers and state ----------------
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_div_q, baud_div_d;
  logic        overflow_q, overflow_d;
  tx_state_t   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;
  logic        busy, slot_end, start_frame;
  logic        frame_par, par_bit;

`ifdef UART_TX_PARITY_EN
  logic frame_par_q, frame_par_d;
  logic par_bit_q, par_bit_d;
  assign frame_par = frame_par_q;
  assign par_bit   = par_bit_q;
`else
  assign frame_par = 1'b0;
  assign par_bit   = 1'b1;
`endif

  assign busy     = (state_q != IDLE);
  assign slot_end = (baud_cnt_q == div_q - 16'd1);
  assign tx       = tx_q;
  assign irq      = irq_q;

  // Software-visible register updates; a dropped push sets overflow over a W1C.
  always_comb begin
    ctrl_d     = ctrl_q;
    baud_div_d = baud_div_q;
    overflow_d = overflow_q;
    if (wr_ctrl) ctrl_d = bus.data_in[3:0] & CTRL_WR_MASK;
    if (wr_baud) baud_div_d = (bus.data_in[15:0] == 16'd0) ? 16'd1 : bus.data_in[15:0];
    if (wr_status && bus.data_in[STAT_OVF]) overflow_d = 1'b0;
    if (push && fifo_full) overflow_d = 1'b1;
  end

  // TX sequencer: one baud slot per state (8 in DATA), frame start pops and latches.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    start_frame = 1'b0;
    pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    frame_par_d = frame_par_q;
    par_bit_d   = par_bit_q;
`endif
    unique case (state_q)
      IDLE:   start_frame = ctrl_q[CTRL_TX_EN] & ~fifo_empty;
      START:  if (slot_end) state_d = DATA;
      DATA: begin
        if (slot_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = frame_par ? PARITY : STOP;
        end
      end
      PARITY: if (slot_end) state_d = STOP;
      STOP: begin
        if (slot_end) begin
          if (ctrl_q[CTRL_TX_EN] && !fifo_empty) start_frame = 1'b1;
          else                                   state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy) baud_cnt_d = slot_end ? 16'd0 : baud_cnt_q + 16'd1;

    if (start_frame) begin
      pop        = 1'b1;
      state_d    = START;
      shift_d    = fifo_rdata;
      div_d      = baud_div_q;
      bit_cnt_d  = 3'd0;
      baud_cnt_d = 16'd0;
`ifdef UART_TX_PARITY_EN
      frame_par_d = ctrl_q[CTRL_PAR_EN];
      par_bit_d   = (^fifo_rdata) ^ ctrl_q[CTRL_PAR_ODD];
`endif
    end

    // tx is registered, so it follows the level of the state being entered.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase

    irq_d = ctrl_q[CTRL_IRQ_EN] & fifo_empty & ~busy;
  end

  // All control and datapath flops; reset restores idle line and defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= 4'd0;
      baud_div_q <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      div_q      <= DEFAULT_DIV;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      frame_par_q <= 1'b0;
      par_bit_q   <= 1'b0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      baud_div_q <= baud_div_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
`ifdef UART_TX_PARITY_EN
      frame_par_q <= frame_par_d;
      par_bit_q   <= par_bit_d;
`endif
    end
  end

  // Combinational read mux; misaligned or out-of-window reads return 0.
  always_comb begin
    bus.data_out = 32'd0;
    if (bus.hit && aligned) begin
      unique case (bus.addr_in[3:0])
        OFF_STATUS: begin
          bus.data_out[STAT_BUSY]                  = busy;
          bus.data_out[STAT_FULL]                  = fifo_full;
          bus.data_out[STAT_EMPTY]                 = fifo_empty;
          bus.data_out[STAT_OVF]                   = overflow_q;
          bus.data_out[STAT_CNT_LSB +: 8]          = 8'(fifo_count);
        end
        OFF_CTRL: bus.data_out[3:0]  = ctrl_q;
        OFF_BAUD: bus.data_out[15:0] = baud_div_q;
        default:  bus.data_out = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed steps with random payloads,
// checked against a register/queue model and an arithmetic frame model.
module tb_mmio_uart_tx;

  typedef logic [7:0] u8_t;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [2:0]  FN_B = 3'b000;
  localparam logic [2:0]  FN_H = 3'b001;
  localparam logic [2:0]  FN_W = 3'b010;
`ifdef UART_TX_PARITY_EN
  localparam logic [3:0]  CTRL_MASK = 4'hF;
`else
  localparam logic [3:0]  CTRL_MASK = 4'h3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tx, irq;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the software-visible state.
  u8_t         model_fifo[$];
  logic        model_ovf;
  logic [3:0]  model_ctrl;
  logic [15:0] model_div;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    int n;
    n = model_fifo.size();
    return {16'h0, 8'(n), 4'h0, model_ovf, (n == 0), (n == 8), busy};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic busy);
    if (a[31:4] != BASE[31:4] || a[1:0] != 2'b00) return 32'h0;
    case (a[3:0])
      4'h4:    return exp_status(busy);
      4'h8:    return {28'h0, model_ctrl};
      4'hC:    return {16'h0, model_div};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    model_fifo.delete();
    model_ovf  = 1'b0;
    model_ctrl = 4'h0;
    model_div  = 16'd16;
  endtask

  // One store: drive during the low phase, committed by the following posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bus.wr_en   = 1'b1;
    bus.addr_in = a;
    bus.data_in = d;
    bus.fn3     = f;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.addr_in = 32'h0;
    bus.data_in = 32'h0;
    bus.fn3     = FN_W;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    if (a[31:4] == BASE[31:4] && a[1:0] == 2'b00) begin
      case (a[3:0])
        4'h0: if (model_fifo.size() == 8) model_ovf = 1'b1;
              else model_fifo.push_back(d[7:0]);
        4'h4: if (f[1:0] == 2'b10 && d[3]) model_ovf = 1'b0;
        4'h8: if (f[1:0] == 2'b10) model_ctrl = d[3:0] & CTRL_MASK;
        4'hC: if (f[1:0] == 2'b10) model_div = (d[15:0] == 16'd0) ? 16'd1 : d[15:0];
        default: ;
      endcase
    end
    bus_write(a, d, f);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.wr_en   = 1'b0;
    bus.addr_in = a;
    bus.fn3     = FN_W;
    #1;
    d = bus.data_out;
    h = bus.hit;
    bus.addr_in = 32'h0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic busy);
    logic [31:0] d;
    logic        h;
    bus_read(a, d, h);
    check({tag, " data"}, d, model_read(a, busy));
    check({tag, " hit"}, 32'(h), 32'(a[31:4] == BASE[31:4]));
  endtask

  // Expected line: per frame a start slot, 8 data slots LSB first, a stop slot,
  // each div cycles, frames contiguous. Cycle 0 is the first START cycle.
  task automatic check_stream(input u8_t frames[$], input int div, input int start_c);
    int          total, f, s;
    logic        exp_tx;
    u8_t         b;
    logic [31:0] st;
    logic        h;
    total = frames.size() * 10 * div;
    for (int c = start_c; c < total; c++) begin
      @(negedge clk);
      f = c / (10 * div);
      s = (c % (10 * div)) / div;
      b = frames[f];
      if (s == 0)      exp_tx = 1'b0;
      else if (s == 9) exp_tx = 1'b1;
      else             exp_tx = b[s-1];
      check($sformatf("tx cycle %0d", c), 32'(tx), 32'(exp_tx));
      bus_read(BASE + 32'h4, st, h);
      check($sformatf("busy cycle %0d", c), 32'(st[0]), 32'd1);
    end
    @(negedge clk);
    check("tx idle after frames", 32'(tx), 32'd1);
    read_check("status after frames", BASE + 32'h4, 1'b0);
  endtask

  task automatic drain(input int div, input int start_c);
    u8_t frames[$];
    frames = model_fifo;
    model_fifo.delete();
    check_stream(frames, div, start_c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u8_t         b;
    int          div;
    logic [31:0] d;
    logic        h;

    bus.wr_en   = 1'b0;
    bus.addr_in = 32'h0;
    bus.data_in = 32'h0;
    bus.fn3     = FN_W;
    rst         = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("reset tx", 32'(tx), 32'd1);
    check("reset irq", 32'(irq), 32'd0);
    read_check("reset status", BASE + 32'h4, 1'b0);
    read_check("reset ctrl", BASE + 32'h8, 1'b0);
    read_check("reset baud", BASE + 32'hC, 1'b0);
    read_check("txdata reads 0", BASE, 1'b0);

    // Frame timing with 0xA5 at div 4.
    reg_write(BASE + 32'hC, 32'd4, FN_W);
    reg_write(BASE, 32'h0000_00A5, FN_B);
    reg_write(BASE + 32'h8, 32'd1, FN_W);
    read_check("status before start", BASE + 32'h4, 1'b0);
    drain(4, 0);

    // Random single frames, random widths for the push, tx_en left on.
    for (int i = 0; i < 3; i++) begin
      div = int'($urandom_range(3, 1));
      reg_write(BASE + 32'hC, 32'(div), FN_W);
      d = $urandom;
      reg_write(BASE, d, 3'($urandom_range(2, 0)));
      drain(div, 0);
    end

    // Back-to-back frames: 0x00 then 0xFF at div 2.
    reg_write(BASE + 32'h8, 32'd0, FN_W);
    reg_write(BASE + 32'hC, 32'd2, FN_W);
    reg_write(BASE, 32'h0000_0000, FN_B);
    reg_write(BASE, 32'h0000_00FF, FN_B);
    reg_write(BASE + 32'h8, 32'd1, FN_W);
    drain(2, 0);

    // Three random back-to-back frames at div 1.
    reg_write(BASE + 32'h8, 32'd0, FN_W);
    reg_write(BASE + 32'hC, 32'd1, FN_W);
    for (int i = 0; i < 3; i++) reg_write(BASE, $urandom, FN_B);
    read_check("status 3 queued", BASE + 32'h4, 1'b0);
    reg_write(BASE + 32'h8, 32'd1, FN_W);
    drain(1, 0);

    // Address decode and width filtering.
    reg_write(BASE + 32'h8, 32'd0, FN_W);
    reg_write(BASE + 32'h2, 32'h0000_00AB, FN_W);
    read_check("misaligned push ignored", BASE + 32'h4, 1'b0);
    reg_write(BASE + 32'hC, 32'd7, FN_W);
    reg_write(BASE + 32'hE, 32'd5, FN_W);
    read_check("misaligned baud ignored", BASE + 32'hC, 1'b0);
    reg_write(BASE + 32'hC, 32'd0, FN_W);
    read_check("baud zero stored as 1", BASE + 32'hC, 1'b0);
    reg_write(BASE + 32'h8, 32'd1, FN_H);
    read_check("halfword ctrl ignored", BASE + 32'h8, 1'b0);
    reg_write(BASE + 32'h8, 32'h0000_000C, FN_W);
    read_check("ctrl parity bits", BASE + 32'h8, 1'b0);
    reg_write(BASE + 32'h8, 32'd0, FN_W);
    read_check("misaligned read", BASE + 32'h5, 1'b0);
    read_check("outside window", BASE + 32'h20, 1'b0);

    // Overflow: nine pushes into an 8-deep FIFO with transmission off.
    for (int i = 0; i < 9; i++) reg_write(BASE, $urandom, FN_B);
    bus_read(BASE + 32'h4, d, h);
    check("status after 9 pushes", d, 32'h0000_080A);
    reg_write(BASE + 32'h5, 32'h8, FN_W);
    read_check("misaligned W1C ignored", BASE + 32'h4, 1'b0);
    reg_write(BASE + 32'h4, 32'h8, FN_W);
    bus_read(BASE + 32'h4, d, h);
    check("status after W1C", d, 32'h0000_0802);

    // Push while full on the same edge as the first pop: dropped, overflow set.
    reg_write(BASE + 32'hC, 32'd1, FN_W);
    reg_write(BASE + 32'h8, 32'd1, FN_W);
    reg_write(BASE, $urandom, FN_B);
    bus_read(BASE + 32'h4, d, h);
    check("status full push with pop", d, 32'h0000_0709);
    drain(1, 1);

    // Interrupt: irq_en with one byte at div 1.
    reg_write(BASE + 32'h8, 32'd0, FN_W);
    reg_write(BASE + 32'h4, 32'h8, FN_W);
    reg_write(BASE, $urandom, FN_B);
    check("irq off before enable", 32'(irq), 32'd0);
    reg_write(BASE + 32'h8, 32'd3, FN_W);
    model_fifo.delete();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("irq step %0d", k), 32'(irq), (k == 12) ? 32'd1 : 32'd0);
      if (k == 10 || k == 11) begin
        bus_read(BASE + 32'h4, d, h);
        check($sformatf("busy step %0d", k), 32'(d[0]), (k == 10) ? 32'd1 : 32'd0);
      end
    end
    reg_write(BASE + 32'h8, 32'd1, FN_W);
    check("irq holds one cycle", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq drops after disable", 32'(irq), 32'd0);

    // Reset in the middle of the DATA phase.
    reg_write(BASE + 32'hC, 32'd4, FN_W);
    b = 8'($urandom);
    reg_write(BASE, {24'h0, b}, FN_B);
    repeat (6) @(negedge clk);
    check("mid-frame data bit0", 32'(tx), 32'(b[0]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("post-reset tx", 32'(tx), 32'd1);
    check("post-reset irq", 32'(irq), 32'd0);
    bus_read(BASE + 32'h4, d, h);
    check("post-reset status", d, 32'h0000_0004);
    bus_read(BASE + 32'hC, d, h);
    check("post-reset baud", d, 32'd16);
    read_check("post-reset ctrl", BASE + 32'h8, 1'b0);

    // One frame at the default divider after reset.
    reg_write(BASE + 32'h8, 32'd1, FN_W);
    reg_write(BASE, $urandom, FN_W);
    drain(16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the core's data-memory bus: decodes stores and loads addressed to its window and serialises bytes onto a UART TX line (8N1, LSB first).
- Sits beside the data memory; the core's load mux selects its `data_out` when `hit`=1. Its `irq` output feeds one interrupt manager IRQ line.
- Contains a byte FIFO, a per-frame baud counter and a TX state machine.

Parameters:
- BASE_ADDR, 32'h1000_0000, window base; 16-byte window, matched on addr_in[31:4].
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, at least 2.
- DEFAULT_DIV, 16'd16, reset value of BAUD_DIV, in clk cycles per bit.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  store strobe from core.
- addr_in  in  32  byte address (core ALU output).
- data_in  in  32  store data (rs2).
- fn3  in  3  load/store width: 000 B, 001 H, 010 W (bit 2 ignored).
- data_out  out  32  combinational read data; 0 when hit=0.
- hit  out  1  combinational: addr_in[31:4]==BASE_ADDR[31:4].
- tx  out  1  serial line; idles high.
- irq  out  1  registered level interrupt.

Behaviour:
- Register map (offsets), with addr_in[1:0] required to be 00:
  - 0x0 TXDATA: write pushes data_in[7:0] for any width; reads 0.
  - 0x4 STATUS: bit0 busy, bit1 full, bit2 empty, bit3 overflow (W1C), bits[15:8] fifo count.
  - 0x8 CTRL: bit0 tx_en, bit1 irq_en; reset 0.
  - 0xC BAUD_DIV: bits[15:0]; reset DEFAULT_DIV; a written 0 is stored as 1.
- Writes:
  - Take effect on the posedge where wr_en=1 and hit=1.
  - CTRL, BAUD_DIV and STATUS accept only fn3=010; other widths are ignored.
  - Misaligned addresses (addr_in[1:0]≠0) are ignored on write and read 0.
- Reads have no side effects.
- FIFO:
  - A push when full (judged before the edge) is dropped and sets overflow, even if a pop occurs the same cycle.
  - Push and pop on the same edge while not full: count unchanged, both performed.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START when tx_en=1 and FIFO non-empty. On that edge: pop byte into shift register, latch BAUD_DIV into div_q, clear bit counter.
  - Each state lasts div_q cycles (baud counter counts 0..div_q-1).
  - START: tx=0.
  - DATA: 8 bits, LSB first; shift on each bit boundary.
  - STOP: tx=1.
  - At end of STOP: if tx_en=1 and FIFO non-empty, go directly to START, with the same pop/latch actions and no idle cycle. Otherwise go to IDLE.
  - Frame = 10·div_q cycles. tx is registered.
- Mid-frame events:
  - Clearing tx_en mid-frame completes the current frame, then the FSM holds in IDLE.
  - A BAUD_DIV write mid-frame applies from the next frame.
- busy = (state≠IDLE).
- irq next = irq_en & empty & ~busy; reset 0.
- Reset (including mid-frame) values on the next edge: tx=1, irq=0, state IDLE, FIFO empty, overflow 0, CTRL 0, BAUD_DIV=DEFAULT_DIV.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - CTRL bit2 par_en and bit3 par_odd become writable.
  - When par_en is latched at frame start, a PARITY state of div_q cycles sits between DATA and STOP.
  - Parity bit = XOR of data bits, inverted if par_odd; frame becomes 11·div_q cycles.
- Undefined: CTRL bits 2–3 read 0, writes to them are ignored, and there is no PARITY state.

Decomposition:
- Package uart_tx_pkg holds:
  - register offset constants;
  - STATUS/CTRL bit-index constants;
  - tx_state_t enum (IDLE, START, DATA, STOP, PARITY).
- One sub-module: tx_fifo, a synchronous FIFO parameterised by width and depth, with push, pop, full, empty and count outputs.

Test Plan:
- Frame timing: BAUD_DIV=4, CTRL=1, SB 0xA5 to TXDATA → tx levels per 4-cycle slot are 0, then bits 1,0,1,0,0,1,0,1, then 1. busy=1 for exactly 40 cycles.
- Back-to-back: BAUD_DIV=2, push 0x00 and 0xFF, CTRL=1 → two frames over 40 contiguous cycles; the second start bit immediately follows the first stop bit.
- Overflow: CTRL=0, push 9 bytes → STATUS=0x0000_080A (count 8, full, overflow). SW 0x8 to STATUS → overflow=0, count still 8.
- Decode: SW to BASE+0x5 → no state change. Load from BASE+0x20 → hit=0, data_out=0. SH to CTRL → ignored.
- IRQ: CTRL=3, one byte sent at div 1 → irq=0 while busy, irq=1 one cycle after the frame ends. Clearing irq_en drops irq next cycle.
- Reset mid-frame: assert rst during DATA → next edge gives tx=1, irq=0, STATUS=0x0000_0004, BAUD_DIV reads 16.
